// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - run/pause/clear elapsed-seconds core with prescaler and saturation
// Optional lap-hold display snapshot is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_counter #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int MAX_SECONDS = 5999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop_i,
  input  logic        clear_i,
  input  logic        lap_i,
  output logic [12:0] seconds_o,
  output logic        running_o,
  output logic        done_o,
  output logic        tick_o
);

  localparam int              PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRE_TC  = PW'(CLK_HZ - 1);
  localparam logic [12:0]     MAX_CNT = 13'(MAX_SECONDS);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [12:0]   count_q, count_d;
  logic          ss_q, ss_rise;
  logic          tick, tick_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      count_q <= '0;
      ss_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      count_q <= count_d;
      ss_q    <= start_stop_i;
      tick_q  <= tick & ~clear_i;
    end
  end

  always_comb begin
    ss_rise = start_stop_i & ~ss_q;
    tick    = (state_q == RUNNING) && (pre_q == PRE_TC);
    state_d = state_q;
    pre_d   = pre_q;
    count_d = count_q;
    if (clear_i) begin
      state_d = IDLE;
      pre_d   = '0;
      count_d = '0;
    end else begin
      if (state_q == RUNNING) begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        // >= also catches a count left at max by a pause on the saturating tick
        if (tick) begin
          if (count_q >= MAX_CNT - 13'd1) begin
            count_d = MAX_CNT;
            state_d = DONE;
          end else begin
            count_d = count_q + 13'd1;
          end
        end
      end
      if (ss_rise) begin
        case (state_q)
          IDLE:    state_d = RUNNING;
          RUNNING: state_d = PAUSED;
          PAUSED:  state_d = RUNNING;
          default: ;
        endcase
      end
    end
  end

  assign running_o = (state_q == RUNNING);
  assign done_o    = (state_q == DONE);
  assign tick_o    = tick_q;

`ifdef STOPWATCH_LAP_EN
  logic        lap_q, lap_rise, hold_q;
  logic [12:0] snap_q;

  assign lap_rise = lap_i & ~lap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q  <= 1'b0;
      hold_q <= 1'b0;
      snap_q <= '0;
    end else begin
      lap_q <= lap_i;
      if (clear_i) begin
        hold_q <= 1'b0;
        snap_q <= '0;
      end else if (lap_rise && (state_q == RUNNING || state_q == PAUSED)) begin
        hold_q <= ~hold_q;
        if (!hold_q) snap_q <= count_q;
      end
    end
  end

  assign seconds_o = hold_q ? snap_q : count_q;
`else
  logic unused_lap;
  assign unused_lap = lap_i;
  assign seconds_o  = count_q;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - self-checking bench for stopwatch_counter
// Reference model counts RUNNING cycles and derives seconds by division.
module tb_stopwatch_counter;

  localparam int CLK_HZ      = 4;
  localparam int MAX_SECONDS = 5999;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
`ifdef STOPWATCH_LAP_EN
  localparam int LAP_HELD_EXP = 1;
`else
  localparam int LAP_HELD_EXP = 4;
`endif

  logic        clk = 1'b0;
  logic        reset, start_stop_i, clear_i, lap_i;
  logic [12:0] seconds_o, sat_seconds;
  logic        running_o, done_o, tick_o;
  logic        sat_running, sat_done, sat_tick;

  int checks = 0;
  int errors = 0;

  int m_mode, m_cyc, m_snap;
  bit m_hold, m_tick, m_ss_prev, m_lap_prev;

  always #5 clk = ~clk;

  stopwatch_counter #(.CLK_HZ(CLK_HZ), .MAX_SECONDS(MAX_SECONDS)) dut (
    .clk(clk), .reset(reset), .start_stop_i(start_stop_i), .clear_i(clear_i),
    .lap_i(lap_i), .seconds_o(seconds_o), .running_o(running_o),
    .done_o(done_o), .tick_o(tick_o)
  );

  stopwatch_counter #(.CLK_HZ(CLK_HZ), .MAX_SECONDS(3)) dut_sat (
    .clk(clk), .reset(reset), .start_stop_i(start_stop_i), .clear_i(clear_i),
    .lap_i(lap_i), .seconds_o(sat_seconds), .running_o(sat_running),
    .done_o(sat_done), .tick_o(sat_tick)
  );

  function automatic int m_live();
    int s;
    s = m_cyc / CLK_HZ;
    return (s > MAX_SECONDS) ? MAX_SECONDS : s;
  endfunction

  function automatic int m_seconds();
    return m_hold ? m_snap : m_live();
  endfunction

  task automatic model_update(input bit rst, input bit ss, input bit clr, input bit lp);
    bit rise;
    int prev_mode;
    m_tick = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_cyc = 0; m_snap = 0;
      m_hold = 1'b0; m_ss_prev = 1'b0; m_lap_prev = 1'b0;
      return;
    end
    rise = ss && !m_ss_prev;
`ifdef STOPWATCH_LAP_EN
    if (lp && !m_lap_prev && !clr && (m_mode == M_RUN || m_mode == M_PAUSE)) begin
      if (!m_hold) m_snap = m_live();
      m_hold = !m_hold;
    end
`endif
    m_ss_prev  = ss;
    m_lap_prev = lp;
    if (clr) begin
      m_mode = M_IDLE; m_cyc = 0; m_hold = 1'b0; m_snap = 0;
      return;
    end
    prev_mode = m_mode;
    if (prev_mode == M_RUN) begin
      m_cyc++;
      if (m_cyc % CLK_HZ == 0) begin
        m_tick = 1'b1;
        if (m_cyc / CLK_HZ >= MAX_SECONDS) m_mode = M_DONE;
      end
    end
    if (rise) begin
      case (prev_mode)
        M_IDLE:  m_mode = M_RUN;
        M_RUN:   m_mode = M_PAUSE;
        M_PAUSE: m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic step();
    bit r, s, c, l;
    r = reset; s = start_stop_i; c = clear_i; l = lap_i;
    @(posedge clk);
    model_update(r, s, c, l);
    #1;
  endtask

  task automatic do_clear();
    clear_i = 1'b1; start_stop_i = 1'b0; lap_i = 1'b0;
    step();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    checks++; if (seconds_o !== 13'd0) begin errors++; $display("FAIL reset_seconds got %0d exp 0", seconds_o); end
    checks++; if (running_o !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
    checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", tick_o); end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (seconds_o !== 13'd0 || running_o !== 1'b0 || tick_o !== 1'b0) begin
        errors++;
        $display("FAIL idle cycle %0d got sec=%0d run=%b tick=%b exp 0/0/0", i, seconds_o, running_o, tick_o);
      end
    end
  endtask

  task automatic test_run_pause();
    do_clear();
    start_stop_i = 1'b1; step(); start_stop_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (tick_o !== m_tick || seconds_o !== 13'(m_seconds())) begin
        errors++;
        $display("FAIL run cycle %0d got tick=%b sec=%0d exp tick=%b sec=%0d", i, tick_o, seconds_o, m_tick, m_seconds());
      end
    end
    checks++; if (seconds_o !== 13'd2) begin errors++; $display("FAIL before_pause got %0d exp 2", seconds_o); end
    start_stop_i = 1'b1; step(); start_stop_i = 1'b0;
    checks++; if (running_o !== 1'b0) begin errors++; $display("FAIL paused_running got %b exp 0", running_o); end
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (seconds_o !== 13'd2 || tick_o !== 1'b0) begin
        errors++;
        $display("FAIL pause cycle %0d got sec=%0d tick=%b exp 2/0", i, seconds_o, tick_o);
      end
    end
    start_stop_i = 1'b1; step(); start_stop_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (tick_o !== m_tick || seconds_o !== 13'(m_seconds())) begin
        errors++;
        $display("FAIL resume cycle %0d got tick=%b sec=%0d exp tick=%b sec=%0d", i, tick_o, seconds_o, m_tick, m_seconds());
      end
    end
    checks++; if (seconds_o !== 13'd4) begin errors++; $display("FAIL after_resume got %0d exp 4", seconds_o); end
  endtask

  task automatic test_saturation();
    do_clear();
    start_stop_i = 1'b1; step(); start_stop_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (sat_seconds > 13'd3) begin errors++; $display("FAIL sat_bound cycle %0d got %0d exp <=3", i, sat_seconds); end
    end
    checks++; if (sat_seconds !== 13'd3) begin errors++; $display("FAIL sat_seconds got %0d exp 3", sat_seconds); end
    checks++; if (sat_done !== 1'b1) begin errors++; $display("FAIL sat_done got %b exp 1", sat_done); end
    checks++; if (sat_running !== 1'b0) begin errors++; $display("FAIL sat_running got %b exp 0", sat_running); end
    start_stop_i = 1'b1; step(); start_stop_i = 1'b0;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (sat_seconds !== 13'd3 || sat_done !== 1'b1 || sat_running !== 1'b0) begin
      errors++;
      $display("FAIL sat_ignore_start got sec=%0d done=%b run=%b exp 3/1/0", sat_seconds, sat_done, sat_running);
    end
  endtask

  task automatic test_clear_priority();
    int n;
    do_clear();
    start_stop_i = 1'b1; step(); start_stop_i = 1'b0;
    n = 0;
    while (seconds_o !== 13'd2 && n < 40) begin step(); n++; end
    checks++; if (seconds_o !== 13'd2) begin errors++; $display("FAIL reach_two got %0d exp 2", seconds_o); end
    clear_i = 1'b1; start_stop_i = 1'b1; step();
    clear_i = 1'b0; start_stop_i = 1'b0;
    checks++;
    if (seconds_o !== 13'd0 || running_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins got sec=%0d run=%b done=%b exp 0/0/0", seconds_o, running_o, done_o);
    end
    step();
    start_stop_i = 1'b1; step(); start_stop_i = 1'b0;
    n = 0;
    while (tick_o !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL restart_tick_latency got %0d exp 4", n); end
    checks++; if (seconds_o !== 13'd1) begin errors++; $display("FAIL restart_seconds got %0d exp 1", seconds_o); end
  endtask

  task automatic test_held_start();
    do_clear();
    start_stop_i = 1'b1;
    step();
    for (int i = 0; i < 29; i++) begin
      step();
      checks++;
      if (running_o !== 1'b1) begin errors++; $display("FAIL held_start cycle %0d got run=%b exp 1", i, running_o); end
    end
    start_stop_i = 1'b0;
    step();
    checks++; if (seconds_o !== 13'(m_seconds())) begin errors++; $display("FAIL held_seconds got %0d exp %0d", seconds_o, m_seconds()); end
  endtask

  task automatic test_lap();
    int n;
    do_clear();
    start_stop_i = 1'b1; step(); start_stop_i = 1'b0;
    n = 0;
    while (seconds_o !== 13'd1 && n < 20) begin step(); n++; end
    checks++; if (seconds_o !== 13'd1) begin errors++; $display("FAIL lap_reach_one got %0d exp 1", seconds_o); end
    lap_i = 1'b1; step(); lap_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (seconds_o !== 13'(m_seconds())) begin errors++; $display("FAIL lap cycle %0d got %0d exp %0d", i, seconds_o, m_seconds()); end
    end
    checks++; if (seconds_o !== 13'(LAP_HELD_EXP)) begin errors++; $display("FAIL lap_hold got %0d exp %0d", seconds_o, LAP_HELD_EXP); end
    lap_i = 1'b1; step(); lap_i = 1'b0;
    checks++; if (seconds_o !== 13'd4) begin errors++; $display("FAIL lap_release got %0d exp 4", seconds_o); end
  endtask

  task automatic test_random();
    do_clear();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) start_stop_i = ~start_stop_i;
      if ($urandom_range(0, 11) == 0) lap_i = ~lap_i;
      clear_i = ($urandom_range(0, 149) == 0);
      step();
      checks++;
      if (seconds_o !== 13'(m_seconds()) || tick_o !== m_tick ||
          running_o !== (m_mode == M_RUN) || done_o !== (m_mode == M_DONE)) begin
        errors++;
        $display("FAIL random cycle %0d got sec=%0d tick=%b run=%b done=%b exp sec=%0d tick=%b run=%b done=%b",
                 i, seconds_o, tick_o, running_o, done_o, m_seconds(), m_tick, m_mode == M_RUN, m_mode == M_DONE);
      end
    end
    clear_i = 1'b0; start_stop_i = 1'b0; lap_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start_stop_i = 1'b0; clear_i = 1'b0; lap_i = 1'b0;
    test_reset();
    test_run_pause();
    test_saturation();
    test_clear_priority();
    test_held_start();
    test_lap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
